// File: rtl/hs_arbiter_2ch.sv
// Two-channel 4-phase handshake arbiter. Both async requesters are synchronized,
// one is granted at a time (round-robin on contention), and a timeout recovers a stuck req.
module hs_arbiter_2ch #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_i,
  input  logic       data0_i,
  output logic       ack0_o,
  input  logic       req1_i,
  input  logic       data1_i,
  output logic       ack1_o,
  output logic       out_o,
  output logic [1:0] grant_o,
  output logic       busy_o,
  output logic       timeout_o
);

  // state    | meaning
  // IDLE     | no owner; grant on synchronized req
  // ACK      | ack high for owner, waiting for req release or timeout
  // RECOVER  | timed out; ack low, grant held until owner drops req
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACK     = 2'd1;
  localparam logic [1:0] ST_RECOVER = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] req0_sync, req1_sync, data0_sync, data1_sync;
  logic [1:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic                   owner;
  logic                   last;

  logic rq0, rq1, d0, d1;
  logic rq_owner;
  logic pick;

  always_ff @(posedge clk) begin
    if (rst) begin
      req0_sync  <= '0;
      req1_sync  <= '0;
      data0_sync <= '0;
      data1_sync <= '0;
    end else begin
      req0_sync  <= {req0_sync[SYNC_STAGES-2:0], req0_i};
      req1_sync  <= {req1_sync[SYNC_STAGES-2:0], req1_i};
      data0_sync <= {data0_sync[SYNC_STAGES-2:0], data0_i};
      data1_sync <= {data1_sync[SYNC_STAGES-2:0], data1_i};
    end
  end

  always_comb begin
    rq0      = req0_sync[SYNC_STAGES-1];
    rq1      = req1_sync[SYNC_STAGES-1];
    d0       = data0_sync[SYNC_STAGES-1];
    d1       = data1_sync[SYNC_STAGES-1];
    rq_owner = owner ? rq1 : rq0;
    // On contention the channel not served last wins; otherwise the lone requester.
    pick     = (rq0 && rq1) ? ~last : rq1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      owner     <= 1'b0;
      last      <= 1'b1;
      ack0_o    <= 1'b0;
      ack1_o    <= 1'b0;
      out_o     <= 1'b0;
      grant_o   <= 2'b00;
      timeout_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rq0 || rq1) begin
            owner   <= pick;
            last    <= pick;
            out_o   <= pick ? d1 : d0;
            ack0_o  <= ~pick;
            ack1_o  <= pick;
            grant_o <= pick ? 2'b10 : 2'b01;
            cnt     <= '0;
            state   <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (!rq_owner) begin
            ack0_o  <= 1'b0;
            ack1_o  <= 1'b0;
            grant_o <= 2'b00;
            state   <= ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            ack0_o    <= 1'b0;
            ack1_o    <= 1'b0;
            timeout_o <= 1'b1;
            state     <= ST_RECOVER;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RECOVER: begin
          if (!rq_owner) begin
            grant_o <= 2'b00;
            state   <= ST_IDLE;
          end
        end
        default: begin
          ack0_o  <= 1'b0;
          ack1_o  <= 1'b0;
          grant_o <= 2'b00;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_hs_arbiter_2ch.sv
// Directed and randomized checks of hs_arbiter_2ch with a short timeout
// so the timeout/recover path is reachable quickly.
module tb_hs_arbiter_2ch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_v  = 2'b00;
  logic [1:0] data_v = 2'b00;
  logic       ack0, ack1, out, busy, timeout;
  logic [1:0] grant;
  logic [1:0] ack_v;

  int n_cmp = 0;
  int n_err = 0;

  assign ack_v = {ack1, ack0};

  hs_arbiter_2ch #(
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(16),
    .CNT_W(5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req0_i   (req_v[0]),
    .data0_i  (data_v[0]),
    .ack0_o   (ack0),
    .req1_i   (req_v[1]),
    .data1_i  (data_v[1]),
    .ack1_o   (ack1),
    .out_o    (out),
    .grant_o  (grant),
    .busy_o   (busy),
    .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Tick until channel ch's ack reaches lvl, checking ack exclusivity each cycle.
  task automatic wait_ack(input int ch, input logic lvl, input string tag);
    int n = 0;
    while (ack_v[ch] !== lvl && n < 30) begin
      tick();
      chk("acks_excl", {31'd0, ack_v == 2'b11}, 0);
      n++;
    end
    chk(tag, {31'd0, ack_v[ch]}, {31'd0, lvl});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   phase [2];
    int   n_hi;
    int   exp_ch;
    logic [1:0] prev_ack;
    logic prev_out;
    logic rise_any;

    // reset state
    rst = 1'b1;
    tick(); tick();
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_out", out, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1'b0;

    // channel 0 handshake, latency SYNC_STAGES edges
    data_v[0] = 1'b1;
    tick();
    req_v[0] = 1'b1;
    tick();
    chk("lat_e0_ack0", ack0, 0);
    tick();
    chk("lat_e1_ack0", ack0, 0);
    tick();
    chk("lat_e2_ack0", ack0, 1);
    chk("lat_e2_out", out, 1);
    chk("lat_e2_grant", grant, 2'b01);
    chk("lat_e2_busy", busy, 1);
    req_v[0] = 1'b0;
    tick();
    chk("rel_f1_ack0", ack0, 1);
    tick();
    chk("rel_f2_ack0", ack0, 1);
    tick();
    chk("rel_f3_ack0", ack0, 0);
    chk("rel_f3_grant", grant, 0);
    chk("rel_f3_busy", busy, 0);

    // channel 1 handshake with data 0
    data_v = 2'b00;
    tick();
    req_v[1] = 1'b1;
    tick();
    chk("ch1_e0_ack0", ack0, 0);
    tick();
    chk("ch1_e1_out", out, 1);
    tick();
    chk("ch1_ack1", ack1, 1);
    chk("ch1_ack0", ack0, 0);
    chk("ch1_out", out, 0);
    chk("ch1_grant", grant, 2'b10);
    req_v[1] = 1'b0;
    wait_ack(1, 1'b0, "ch1_release");
    chk("ch1_rel_grant", grant, 0);
    chk("ch1_rel_ack0", ack0, 0);

    // simultaneous requests: round-robin 0,1,0,1
    data_v = 2'b01;
    tick();
    req_v = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_ch = i % 2;
      n_hi = 0;
      while (ack_v == 2'b00 && n_hi < 30) begin
        tick();
        chk("rr_acks_excl", {31'd0, ack_v == 2'b11}, 0);
        n_hi++;
      end
      chk("rr_ack", ack_v, (exp_ch == 1) ? 2'b10 : 2'b01);
      chk("rr_grant", grant, (exp_ch == 1) ? 2'b10 : 2'b01);
      chk("rr_out", out, data_v[exp_ch]);
      req_v[exp_ch] = 1'b0;
      wait_ack(exp_ch, 1'b0, "rr_release");
      if (i < 2) req_v[exp_ch] = 1'b1;
    end
    repeat (5) tick();
    chk("rr_idle_busy", busy, 0);
    chk("rr_idle_acks", ack_v, 0);

    // timeout on channel 1 with channel 0 pending
    data_v = 2'b10;
    tick();
    req_v[1] = 1'b1;
    wait_ack(1, 1'b1, "to_grant1");
    req_v[0] = 1'b1;
    n_hi = 1;
    while (ack1 === 1'b1 && n_hi < 40) begin
      tick();
      if (ack1 === 1'b1) n_hi++;
    end
    chk("to_ack_high_cycles", n_hi, 16);
    chk("to_flag", timeout, 1);
    chk("to_grant_held", grant, 2'b10);
    chk("to_busy", busy, 1);
    chk("to_out_held", out, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("to_no_grant0", ack0, 0);
      chk("to_grant_keep", grant, 2'b10);
      chk("to_flag_sticky", timeout, 1);
    end
    req_v[1] = 1'b0;
    tick();
    tick();
    tick();
    chk("rec_exit_grant", grant, 0);
    chk("rec_exit_ack0", ack0, 0);
    tick();
    chk("rec_grant0_ack", ack0, 1);
    chk("rec_grant0_out", out, 0);
    chk("rec_grant0_grant", grant, 2'b01);
    chk("rec_flag_sticky", timeout, 1);

    // reset mid-handshake with req0 held
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ack0", ack0, 0);
    chk("mid_rst_out", out, 0);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_timeout", timeout, 0);
    tick();
    chk("regrant_r1", ack0, 0);
    tick();
    chk("regrant_r2", ack0, 0);
    tick();
    chk("regrant_r3", ack0, 1);
    chk("regrant_grant", grant, 2'b01);
    req_v[0] = 1'b0;
    wait_ack(0, 1'b0, "regrant_release");
    repeat (4) tick();
    chk("pre_rnd_busy", busy, 0);

    // randomized 4-phase clients with scoreboard
    phase[0] = 0;
    phase[1] = 0;
    prev_ack = ack_v;
    prev_out = out;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      tick();
      chk("rnd_acks_excl", {31'd0, ack_v == 2'b11}, 0);
      rise_any = 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
        if (ack_v[ch] && !prev_ack[ch]) begin
          rise_any = 1'b1;
          chk("rnd_ack_phase", phase[ch], 2);
          chk("rnd_out", out, data_v[ch]);
          chk("rnd_grant", grant, (ch == 1) ? 2'b10 : 2'b01);
          phase[ch] = 3;
        end
        if (!ack_v[ch] && prev_ack[ch] && req_v[ch]) chk("rnd_early_drop", timeout, 1);
      end
      if (out !== prev_out) chk("rnd_out_chg", rise_any, 1);
      for (int ch = 0; ch < 2; ch++) begin
        case (phase[ch])
          0: if (!ack_v[ch] && ($urandom % 4) == 0) begin
               data_v[ch] = $urandom_range(0, 1);
               phase[ch] = 1;
             end
          1: begin
               req_v[ch] = 1'b1;
               phase[ch] = 2;
             end
          3: if (($urandom % 8) == 0) begin
               req_v[ch] = 1'b0;
               phase[ch] = 4;
             end
          4: if (!ack_v[ch]) phase[ch] = 0;
          default: ;
        endcase
      end
      prev_ack = ack_v;
      prev_out = out;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
